pooling_ctrl: RTL and testbench

Control sequencer for the pooling stage. It drives the mux select, register-file write and address controls, and result-valid strobes of the pooling datapath, so that a row-major stream of systolic-array outputs is reduced by 2x2, stride-2 pooling. It sits between the systolic array's output stream and the pooling datapath. It is the initiator for every control input of that datapath.

---
 rtl/pooling_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pooling_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_ctrl.sv
// Control sequencer for 2x2 stride-2 pooling over a row-major stream of systolic outputs.
// Drives mux select, register-file write/address controls and result strobes of the pooling datapath.
module pooling_ctrl #(
    parameter int data_width = 16,
    parameter int MAX_W      = 32,
    parameter int AW         = $clog2(MAX_W / 2),
    parameter int DW         = $clog2(MAX_W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   fm_width,
    input  logic [DW-1:0]   fm_height,
    input  logic            sys_valid,
    output logic            sel_sys,
    output logic            rf_wr_en,
    output logic            rf_wr_src,
    output logic [AW-1:0]   rf_rd_addr,
    output logic [AW-1:0]   rf_wr_addr,
    output logic            out_valid,
    output logic [2*AW-1:0] out_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    if (((MAX_W % 2) != 0) || (data_width < 1)) begin : g_param_check
        $error("pooling_ctrl: MAX_W must be even and data_width positive");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0]   ONE_D   = DW'(1);
    localparam logic [DW-1:0]   TWO_D   = DW'(2);
    localparam logic [DW-1:0]   MAX_D   = DW'(MAX_W);
    localparam logic [2*AW-1:0] ONE_IDX = (2 * AW)'(1);

    state_t          state_q, state_d;
    logic [DW-1:0]   w_q, w_d;
    logic [DW-1:0]   h_q, h_d;
    logic [DW-1:0]   col_q, col_d;
    logic [DW-1:0]   row_q, row_d;
    logic [2*AW-1:0] idx_q, idx_d;
    logic            err_q, err_d;

    logic dims_ok;
    logic accept;
    logic consume;
    logic last_col;
    logic last_row;

    always_comb begin
        dims_ok  = !fm_width[0] && !fm_height[0] &&
                   (fm_width >= TWO_D) && (fm_width <= MAX_D) &&
                   (fm_height >= TWO_D) && (fm_height <= MAX_D);
        accept   = (state_q == S_IDLE) && start && dims_ok;
        consume  = (state_q == S_RUN) && sys_valid;
        last_col = (col_q == (w_q - ONE_D));
        last_row = (row_q == (h_q - ONE_D));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (consume && last_col && last_row) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath counters; everything advances only on a consumed element
    always_comb begin
        w_d   = w_q;
        h_d   = h_q;
        col_d = col_q;
        row_d = row_q;
        idx_d = idx_q;
        err_d = (state_q == S_IDLE) && start && !dims_ok;
        if (accept) begin
            w_d   = fm_width;
            h_d   = fm_height;
            col_d = '0;
            row_d = '0;
            idx_d = '0;
        end else if (consume) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ONE_D;
            end else begin
                col_d = col_q + ONE_D;
            end
            if (row_q[0] && col_q[0]) begin
                idx_d = idx_q + ONE_IDX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q   <= '0;
            h_q   <= '0;
            col_q <= '0;
            row_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            w_q   <= w_d;
            h_q   <= h_d;
            col_q <= col_d;
            row_q <= row_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    // Output logic: write/valid controls are combinational so the RF writes at this element's edge
    always_comb begin
        sel_sys    = 1'b0;
        rf_wr_en   = 1'b0;
        rf_wr_src  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rf_rd_addr = col_q[AW:1];
        rf_wr_addr = col_q[AW:1];
        out_idx    = idx_q;
        err        = err_q;
        case (state_q)
            S_RUN: begin
                busy = 1'b1;
                if (sys_valid) begin
                    sel_sys = 1'b1;
                    case ({row_q[0], col_q[0]})
                        2'b00: begin
                            rf_wr_en  = 1'b1;
                            rf_wr_src = 1'b0;
                        end
                        2'b01, 2'b10: begin
                            rf_wr_en  = 1'b1;
                            rf_wr_src = 1'b1;
                        end
                        default: begin
                            out_valid = 1'b1;
                        end
                    endcase
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pooling_ctrl.sv
// Scoreboard bench for pooling_ctrl: stimulus pushes hand-computed control records,
// a negedge monitor pops one record whenever the controller shows any activity.
module tb_pooling_ctrl;

    localparam int MAX_W = 32;
    localparam int AW    = 4;
    localparam int DW    = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [DW-1:0]   fm_width;
    logic [DW-1:0]   fm_height;
    logic            sys_valid;
    logic            sel_sys;
    logic            rf_wr_en;
    logic            rf_wr_src;
    logic [AW-1:0]   rf_rd_addr;
    logic [AW-1:0]   rf_wr_addr;
    logic            out_valid;
    logic [2*AW-1:0] out_idx;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    pooling_ctrl #(
        .data_width(16),
        .MAX_W     (MAX_W),
        .AW        (AW),
        .DW        (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fm_width  (fm_width),
        .fm_height (fm_height),
        .sys_valid (sys_valid),
        .sel_sys   (sel_sys),
        .rf_wr_en  (rf_wr_en),
        .rf_wr_src (rf_wr_src),
        .rf_rd_addr(rf_rd_addr),
        .rf_wr_addr(rf_wr_addr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic            sel;
        logic            we;
        logic            src;
        logic [AW-1:0]   addr;
        logic            ov;
        logic [2*AW-1:0] idx;
        logic            busy;
        logic            done;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;

    // Hand-computed 4x4 element table (k = row*4 + col)
    int t44_we [16] = '{1,1,1,1, 1,0,1,0, 1,1,1,1, 1,0,1,0};
    int t44_src[16] = '{0,1,0,1, 1,0,1,0, 0,1,0,1, 1,0,1,0};
    int t44_adr[16] = '{0,0,1,1, 0,0,1,1, 0,0,1,1, 0,0,1,1};
    int t44_ov [16] = '{0,0,0,0, 0,1,0,1, 0,0,0,0, 0,1,0,1};
    int t44_idx[16] = '{0,0,0,0, 0,0,1,1, 2,2,2,2, 2,2,3,3};

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push_el(int we, int src, int addr, int ov, int idx);
        exp_t e;
        e      = '0;
        e.sel  = 1'b1;
        e.we   = we[0];
        e.src  = src[0];
        e.addr = addr[AW-1:0];
        e.ov   = ov[0];
        e.idx  = idx[2*AW-1:0];
        e.busy = 1'b1;
        q.push_back(e);
    endtask

    task automatic push_done(int idx);
        exp_t e;
        e      = '0;
        e.done = 1'b1;
        e.idx  = idx[2*AW-1:0];
        q.push_back(e);
    endtask

    task automatic push_err(int idx);
        exp_t e;
        e     = '0;
        e.err = 1'b1;
        e.idx = idx[2*AW-1:0];
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_map(int w, int h);
        fm_width  = w[DW-1:0];
        fm_height = h[DW-1:0];
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic check_zero(string name);
        @(negedge clk);
        chk(name, int'({sel_sys, rf_wr_en, rf_wr_src, rf_rd_addr, rf_wr_addr,
                        out_valid, out_idx, busy, done, err}), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: any asserted control/strobe is one transaction
    exp_t mon_e;
    logic mon_ok;
    always @(negedge clk) begin
        if (sel_sys || rf_wr_en || out_valid || done || err) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got sel=%0d we=%0d ov=%0d done=%0d err=%0d, required no activity",
                         sel_sys, rf_wr_en, out_valid, done, err);
            end else begin
                mon_e  = q.pop_front();
                mon_ok = (sel_sys == mon_e.sel) && (rf_wr_en == mon_e.we) &&
                         (!mon_e.we || (rf_wr_src == mon_e.src)) &&
                         (rf_rd_addr == mon_e.addr) && (rf_wr_addr == mon_e.addr) &&
                         (out_valid == mon_e.ov) && (out_idx == mon_e.idx) &&
                         (busy == mon_e.busy) && (done == mon_e.done) && (err == mon_e.err);
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL event: got sel=%0d we=%0d src=%0d rd=%0d wr=%0d ov=%0d idx=%0d busy=%0d done=%0d err=%0d required sel=%0d we=%0d src=%0d addr=%0d ov=%0d idx=%0d busy=%0d done=%0d err=%0d",
                             sel_sys, rf_wr_en, rf_wr_src, rf_rd_addr, rf_wr_addr, out_valid, out_idx, busy, done, err,
                             mon_e.sel, mon_e.we, mon_e.src, mon_e.addr, mon_e.ov, mon_e.idx, mon_e.busy, mon_e.done, mon_e.err);
                end else begin
                    $display("evt t=%0t we=%0d src=%0d addr=%0d ov=%0d idx=%0d done=%0d err=%0d",
                             $time, rf_wr_en, rf_wr_src, rf_wr_addr, out_valid, out_idx, done, err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[7]    = '{1,0,0,1,1,0,1};
        int g_we[4]   = '{1,1,1,0};
        int g_src[4]  = '{0,1,1,0};
        int g_ov[4]   = '{0,0,0,1};
        int s8_src[8] = '{0,1,0,1,0,1,0,1};
        int s8_adr[8] = '{0,0,1,1,2,2,3,3};
        int r1_we[8]  = '{1,0,1,0,1,0,1,0};
        int r1_ov[8]  = '{0,1,0,1,0,1,0,1};
        int bad_w[3]  = '{3, 4, MAX_W + 2};
        int bad_h[3]  = '{4, 0, 4};
        int n;

        rst       = 1'b1;
        start     = 1'b0;
        sys_valid = 1'b0;
        fm_width  = '0;
        fm_height = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;

        // Reset during element 5 of a 4x4 map
        start_map(4, 4);
        for (int k = 0; k < 6; k++) begin
            push_el(t44_we[k], t44_src[k], t44_adr[k], t44_ov[k], t44_idx[k]);
            sys_valid = 1'b1;
            rst       = (k == 5);
            tick();
        end
        rst       = 1'b0;
        sys_valid = 1'b0;
        check_zero("midrun_reset");

        // Full 4x4 with a start during RUN and another in the DONE cycle
        busy_cnt = 0;
        start_map(4, 4);
        for (int k = 0; k < 16; k++) begin
            push_el(t44_we[k], t44_src[k], t44_adr[k], t44_ov[k], t44_idx[k]);
            sys_valid = 1'b1;
            start     = (k == 8);
            fm_width  = (k == 8) ? DW'(2) : DW'(4);
            fm_height = (k == 8) ? DW'(2) : DW'(4);
            tick();
        end
        sys_valid = 1'b0;
        push_done(4);
        start     = 1'b1;
        fm_width  = DW'(4);
        fm_height = DW'(4);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("busy_cycles_4x4", busy_cnt, 16);

        // sys_valid while idle
        sys_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("idle_sys_valid_wr_en", rf_wr_en, 0);
            @(posedge clk);
            #1;
        end
        sys_valid = 1'b0;

        // 2x2 with gaps in sys_valid
        start_map(2, 2);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (pat[i] != 0) begin
                push_el(g_we[n], g_src[n], 0, g_ov[n], 0);
                n++;
            end
            sys_valid = pat[i][0];
            tick();
        end
        sys_valid = 1'b0;
        push_done(1);
        tick();
        tick();

        // 8x2 address walk
        start_map(8, 2);
        for (int c = 0; c < 8; c++) begin
            push_el(1, s8_src[c], s8_adr[c], 0, 0);
            sys_valid = 1'b1;
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            push_el(r1_we[c], 1, s8_adr[c], r1_ov[c], s8_adr[c]);
            sys_valid = 1'b1;
            tick();
        end
        sys_valid = 1'b0;
        push_done(4);
        tick();
        tick();

        // Rejected dimensions
        for (int i = 0; i < 3; i++) begin
            start_map(bad_w[i], bad_h[i]);
            push_err(4);
            tick();
            @(negedge clk);
            chk("bad_dims_busy", busy, 0);
            @(posedge clk);
            #1;
        end

        repeat (2) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
